// File: rtl/tcm_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tcm_lsu
//  Description : Load/store initiator for the TCM data port. Accepts one RV32
//                load or store, issues one or two TCM beats, captures the
//                registered TCM read data and returns an aligned, extended
//                single-cycle response.
//  Ports       : i_clk, i_reset (async, active-high)
//                i_req_*  : request from the memory stage (valid/ready)
//                o_rsp_*  : one-cycle response pulse (valid, rdata, err)
//                o_data_* : TCM port (sel, word addr, write, byte mask, wdata)
//                i_data   : TCM registered read data
//  Options     : LSU_MISALIGN_EN - split word-crossing half/word accesses
//                into two TCM beats; undefined -> such accesses error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcm_lsu #(
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [2:0]                i_req_funct3,
    input  logic [31:0]               i_req_addr,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_rsp_valid,
    output logic [31:0]               o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_data_sel,
    output logic [MEM_ADDR_WIDTH-1:0] o_data_addr,
    output logic                      o_data_write,
    output logic [3:0]                o_data_mask,
    output logic [31:0]               o_data,
    input  logic [31:0]               i_data
);

`ifdef LSU_MISALIGN_EN
    localparam logic c_misalign = 1'b1;
`else
    localparam logic c_misalign = 1'b0;
`endif

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_BEAT0   = 3'd1;
    localparam logic [2:0] S_BEAT1   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    localparam logic [MEM_ADDR_WIDTH-1:0] c_addr_one = MEM_ADDR_WIDTH'(1);

    logic [2:0]                r_state;
    logic                      r_write;
    logic [2:0]                r_funct3;
    logic [1:0]                r_b;
    logic                      r_split;
    logic [3:0]                r_mask_hi;
    logic [31:0]               r_data_hi;
    logic [31:0]               r_lo;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_sel;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic                      r_wr;
    logic [3:0]                r_mask;
    logic [31:0]               r_data;

    // ---- request decode (only consumed at the accept edge) ----
    logic [1:0]  w_b;
    logic [3:0]  w_size_mask;
    logic [7:0]  w_lane_mask;
    logic [63:0] w_wdata64;
    logic        w_split;
    logic        w_addr_err;
    logic        w_f3_err;
    logic        w_req_err;

    assign w_b = i_req_addr[1:0];

    always_comb begin
        w_size_mask = 4'hF;
        case (i_req_funct3[1:0])
            2'b00:   w_size_mask = 4'h1;
            2'b01:   w_size_mask = 4'h3;
            default: w_size_mask = 4'hF;
        endcase
    end

    // Lanes and data laid out across two words; the upper half is beat1.
    assign w_lane_mask = {4'b0000, w_size_mask} << w_b;
    assign w_wdata64   = {32'b0, i_req_wdata} << {w_b, 3'b000};
    assign w_split     = |w_lane_mask[7:4];

    assign w_addr_err = |i_req_addr[31:MEM_ADDR_WIDTH+2];
    // Loads reject 011/110/111; stores reject everything above SW.
    assign w_f3_err   = i_req_write ? (i_req_funct3[2] | (i_req_funct3[1:0] == 2'b11))
                                    : ((i_req_funct3[1:0] == 2'b11) | (i_req_funct3 == 3'b110));
    assign w_req_err  = w_addr_err | w_f3_err | (w_split & ~c_misalign);

    // ---- load data alignment and extension ----
    logic [63:0] w_rd64;
    logic [31:0] w_rd32;
    logic [31:0] w_load_data;

    // For a split load r_lo holds beat0; i_data is always the final beat.
    assign w_rd64 = r_split ? {i_data, r_lo} : {32'b0, i_data};
    assign w_rd32 = 32'(w_rd64 >> {r_b, 3'b000});

    always_comb begin
        w_load_data = w_rd32;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_rd32[7]}}, w_rd32[7:0]};
            3'b001:  w_load_data = {{16{w_rd32[15]}}, w_rd32[15:0]};
            3'b100:  w_load_data = {24'b0, w_rd32[7:0]};
            3'b101:  w_load_data = {16'b0, w_rd32[15:0]};
            default: w_load_data = w_rd32;
        endcase
    end

    // ---- control and registered outputs ----
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_b         <= 2'b00;
            r_split     <= 1'b0;
            r_mask_hi   <= 4'b0000;
            r_data_hi   <= 32'b0;
            r_lo        <= 32'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'b0;
            r_rsp_err   <= 1'b0;
            r_sel       <= 1'b0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_mask      <= 4'b0000;
            r_data      <= 32'b0;
        end else begin
            // Response fields are a one-cycle pulse unless set below.
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_write   <= i_req_write;
                        r_funct3  <= i_req_funct3;
                        r_b       <= w_b;
                        r_split   <= w_split;
                        r_mask_hi <= i_req_write ? w_lane_mask[7:4] : 4'b0000;
                        r_data_hi <= w_wdata64[63:32];
                        if (w_req_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= S_BEAT0;
                            r_sel   <= 1'b1;
                            r_wr    <= i_req_write;
                            r_addr  <= i_req_addr[MEM_ADDR_WIDTH+1:2];
                            r_mask  <= i_req_write ? w_lane_mask[3:0] : 4'b0000;
                            if (i_req_write)
                                r_data <= w_wdata64[31:0];
                        end
                    end
                end
                S_BEAT0: begin
                    if (r_split) begin
                        r_state <= S_BEAT1;
                        r_addr  <= r_addr + c_addr_one;   // wraps at the top word
                        r_mask  <= r_mask_hi;
                        if (r_write)
                            r_data <= r_data_hi;
                    end else begin
                        r_sel  <= 1'b0;
                        r_wr   <= 1'b0;
                        r_mask <= 4'b0000;
                        if (r_write) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_BEAT1: begin
                    r_lo   <= i_data;   // beat0 read data arrives now
                    r_sel  <= 1'b0;
                    r_wr   <= 1'b0;
                    r_mask <= 4'b0000;
                    if (r_write) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_load_data;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE) & ~i_reset;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_rsp_err    = r_rsp_err;
    assign o_data_sel   = r_sel;
    assign o_data_addr  = r_addr;
    assign o_data_write = r_wr;
    assign o_data_mask  = r_mask;
    assign o_data       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_tcm_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcm_lsu
//  Description : Self-checking bench for tcm_lsu with a registered-read TCM
//                model and a byte-addressed reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcm_lsu;
    localparam int AW = 8;
    localparam int NW = 1 << AW;
    localparam int NB = NW * 4;
`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic          clk;
    logic          i_reset;
    logic          i_req_valid, o_req_ready, i_req_write;
    logic [2:0]    i_req_funct3;
    logic [31:0]   i_req_addr, i_req_wdata;
    logic          o_rsp_valid, o_rsp_err;
    logic [31:0]   o_rsp_rdata;
    logic          o_data_sel, o_data_write;
    logic [AW-1:0] o_data_addr;
    logic [3:0]    o_data_mask;
    logic [31:0]   o_data, i_data;

    tcm_lsu #(.MEM_ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_data_sel(o_data_sel), .o_data_addr(o_data_addr), .o_data_write(o_data_write),
        .o_data_mask(o_data_mask), .o_data(o_data), .i_data(i_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TCM model: registered read, byte-masked write, plus a preload port.
    logic [31:0]   mem [NW];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (o_data_sel) begin
            if (o_data_write)
                for (int k = 0; k < 4; k++)
                    if (o_data_mask[k]) mem[o_data_addr][8*k +: 8] <= o_data[8*k +: 8];
            i_data <= mem[o_data_addr];
        end
    end

    logic [7:0] ref_mem [NB];
    int n_cmp = 0;
    int n_fail = 0;

    // Captured observation of one transaction
    int            cap_lat, cap_beats;
    logic [31:0]   cap_rdata;
    logic          cap_err;
    logic [AW-1:0] cap_a [2];
    logic [3:0]    cap_m [2];
    logic [31:0]   cap_d [2];
    logic          cap_w [2];

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_split(input logic [31:0] addr, input logic [2:0] f3);
        return (int'(addr[1:0]) + nbytes(f3)) > 4;
    endfunction

    function automatic bit model_err(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
        bit ill;
        ill = wr ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        return (addr[31:10] != 0) || ill || (is_split(addr, f3) && !MIS);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v;
        int n, ba;
        v = 0; n = nbytes(f3); ba = int'(addr[9:0]);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(ba + i) % NB];
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // Which byte lanes of word w a request touches
    function automatic logic [3:0] exp_mask(input logic [31:0] addr, input logic [2:0] f3, input int w);
        logic [3:0] m;
        int b;
        m = 0;
        for (int i = 0; i < nbytes(f3); i++) begin
            b = (int'(addr[9:0]) + i) % NB;
            if (b / 4 == w) m[b % 4] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < nbytes(f3); i++) ref_mem[(int'(addr[9:0]) + i) % NB] = wd[8*i +: 8];
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = AW'(w); pl_data = v;
        @(posedge clk); #1 pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!o_req_ready && guard < 20) begin @(negedge clk); guard++; end
        i_req_valid = 1'b1; i_req_write = wr; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wd;
        @(posedge clk); #1 i_req_valid = 1'b0;
        cap_lat = 0; cap_beats = 0; cap_rdata = 'x; cap_err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (o_data_sel) begin
                if (cap_beats < 2) begin
                    cap_a[cap_beats] = o_data_addr; cap_m[cap_beats] = o_data_mask;
                    cap_d[cap_beats] = o_data;      cap_w[cap_beats] = o_data_write;
                end
                cap_beats++;
            end
            if (o_rsp_valid) begin
                cap_lat = c; cap_rdata = o_rsp_rdata; cap_err = o_rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_req_ready); end
        n_cmp++; if ({o_rsp_valid, o_rsp_err, o_rsp_rdata} !== 34'b0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b/%h want 0", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
        n_cmp++; if ({o_data_sel, o_data_write, o_data_mask, o_data_addr, o_data} !== 46'b0) begin n_fail++; $display("FAIL reset_tcm: got sel %b wr %b mask %b addr %h data %h want 0", o_data_sel, o_data_write, o_data_mask, o_data_addr, o_data); end
        i_reset = 1'b0;
        #1;
        n_cmp++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_req_ready); end
    endtask

    task automatic test_load_lb();
        preload(32'h10, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h41, 32'h0);
        n_cmp++; if (cap_lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", cap_lat); end
        n_cmp++; if ({cap_err, cap_rdata} !== {1'b0, 32'hFFFFFFAA}) begin n_fail++; $display("FAIL lb_data: got err %b rdata %h want 0 ffffffaa", cap_err, cap_rdata); end
        n_cmp++; if (cap_beats !== 1 || cap_a[0] !== 8'h10 || cap_m[0] !== 4'b0000 || cap_w[0] !== 1'b0) begin n_fail++; $display("FAIL lb_beat: got beats %0d addr %h mask %b wr %b want 1 10 0000 0", cap_beats, cap_a[0], cap_m[0], cap_w[0]); end
    endtask

    task automatic test_store_sh();
        do_req(1'b1, 3'b001, 32'h42, 32'hABCD1234);
        model_store(32'h42, 3'b001, 32'hABCD1234);
        n_cmp++; if (cap_lat !== 2) begin n_fail++; $display("FAIL sh_latency: got %0d want 2", cap_lat); end
        n_cmp++; if (cap_beats !== 1 || cap_m[0] !== 4'b1100 || cap_d[0][31:16] !== 16'h1234 || cap_w[0] !== 1'b1) begin n_fail++; $display("FAIL sh_beat: got beats %0d mask %b data %h wr %b want 1 1100 1234xxxx 1", cap_beats, cap_m[0], cap_d[0], cap_w[0]); end
        n_cmp++; if ({cap_err, cap_rdata} !== 33'b0) begin n_fail++; $display("FAIL sh_rsp: got err %b rdata %h want 0 0", cap_err, cap_rdata); end
        @(negedge clk);
        n_cmp++; if (mem[8'h10] !== 32'h1234AABB) begin n_fail++; $display("FAIL sh_mem: got %h want 1234aabb", mem[8'h10]); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_EN
        preload(32'h10, 32'h44332211);
        preload(32'h11, 32'h88776655);
        do_req(1'b0, 3'b010, 32'h43, 32'h0);
        n_cmp++; if (cap_lat !== 4 || cap_rdata !== 32'h77665544 || cap_err !== 1'b0) begin n_fail++; $display("FAIL split_lw: got lat %0d rdata %h err %b want 4 77665544 0", cap_lat, cap_rdata, cap_err); end
        n_cmp++; if (cap_beats !== 2 || cap_a[0] !== 8'h10 || cap_a[1] !== 8'h11) begin n_fail++; $display("FAIL split_lw_beats: got %0d %h %h want 2 10 11", cap_beats, cap_a[0], cap_a[1]); end
        do_req(1'b1, 3'b010, 32'h3FF, 32'hDDCCBBAA);
        model_store(32'h3FF, 3'b010, 32'hDDCCBBAA);
        n_cmp++; if (cap_lat !== 3 || cap_beats !== 2) begin n_fail++; $display("FAIL split_sw_timing: got lat %0d beats %0d want 3 2", cap_lat, cap_beats); end
        n_cmp++; if (cap_a[0] !== 8'hFF || cap_m[0] !== 4'b1000 || cap_d[0] !== 32'hAA000000) begin n_fail++; $display("FAIL split_sw_beat0: got %h %b %h want ff 1000 aa000000", cap_a[0], cap_m[0], cap_d[0]); end
        n_cmp++; if (cap_a[1] !== 8'h00 || cap_m[1] !== 4'b0111 || cap_d[1] !== 32'h00DDCCBB) begin n_fail++; $display("FAIL split_sw_beat1: got %h %b %h want 00 0111 00ddccbb", cap_a[1], cap_m[1], cap_d[1]); end
`else
        do_req(1'b0, 3'b010, 32'h41, 32'h0);
        n_cmp++; if (cap_lat !== 1 || cap_err !== 1'b1 || cap_rdata !== 32'h0 || cap_beats !== 0) begin n_fail++; $display("FAIL misaligned_lw_err: got lat %0d err %b rdata %h beats %0d want 1 1 0 0", cap_lat, cap_err, cap_rdata, cap_beats); end
        do_req(1'b0, 3'b001, 32'h41, 32'h0);
        n_cmp++; if (cap_lat !== 3 || cap_err !== 1'b0 || cap_rdata !== model_load(32'h41, 3'b001)) begin n_fail++; $display("FAIL inword_lh: got lat %0d err %b rdata %h want 3 0 %h", cap_lat, cap_err, cap_rdata, model_load(32'h41, 3'b001)); end
`endif
    endtask

    task automatic test_errors();
        do_req(1'b0, 3'b010, 32'h400, 32'h0);
        n_cmp++; if (cap_lat !== 1 || cap_err !== 1'b1 || cap_rdata !== 32'h0 || cap_beats !== 0) begin n_fail++; $display("FAIL err_addr: got lat %0d err %b rdata %h beats %0d want 1 1 0 0", cap_lat, cap_err, cap_rdata, cap_beats); end
        do_req(1'b0, 3'b011, 32'h40, 32'h0);
        n_cmp++; if (cap_lat !== 1 || cap_err !== 1'b1 || cap_rdata !== 32'h0 || cap_beats !== 0) begin n_fail++; $display("FAIL err_funct3_load: got lat %0d err %b rdata %h beats %0d want 1 1 0 0", cap_lat, cap_err, cap_rdata, cap_beats); end
        do_req(1'b1, 3'b100, 32'h40, 32'h12345678);
        n_cmp++; if (cap_lat !== 1 || cap_err !== 1'b1 || cap_beats !== 0) begin n_fail++; $display("FAIL err_funct3_store: got lat %0d err %b beats %0d want 1 1 0", cap_lat, cap_err, cap_beats); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] rdy, rsp;
        logic [31:0] wd;
        wd = $urandom;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_funct3 = 3'b010; i_req_addr = 32'h80; i_req_wdata = wd;
        for (int k = 0; k < 9; k++) begin
            rdy[k] = o_req_ready; rsp[k] = o_rsp_valid;
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        model_store(32'h80, 3'b010, wd);
        n_cmp++; if (rdy !== 9'b001001001) begin n_fail++; $display("FAIL b2b_ready: got %b want 001001001", rdy); end
        n_cmp++; if (rsp !== 9'b100100100) begin n_fail++; $display("FAIL b2b_rsp: got %b want 100100100", rsp); end
        @(negedge clk);
        n_cmp++; if (mem[8'h20] !== ref_word(32'h20)) begin n_fail++; $display("FAIL b2b_mem: got %h want %h", mem[8'h20], ref_word(32'h20)); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_funct3 = 3'b010; i_req_addr = 32'h90; i_req_wdata = ~ref_word(32'h24);
        @(posedge clk); #1 i_req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_data_write !== 1'b1) begin n_fail++; $display("FAIL rmid_beat0_write: got %b want 1", o_data_write); end
        i_reset = 1'b1;
        #1;
        n_cmp++; if ({o_data_write, o_data_sel, o_req_ready} !== 3'b000) begin n_fail++; $display("FAIL rmid_strobes: got wr %b sel %b rdy %b want 0 0 0", o_data_write, o_data_sel, o_req_ready); end
        @(negedge clk);
        i_reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin @(negedge clk); if (o_rsp_valid) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rmid_no_rsp: got %0d pulses want 0", pulses); end
        n_cmp++; if (mem[8'h24] !== ref_word(32'h24)) begin n_fail++; $display("FAIL rmid_mem: got %h want %h", mem[8'h24], ref_word(32'h24)); end
        do_req(1'b0, 3'b010, 32'h90, 32'h0);
        n_cmp++; if (cap_lat !== 3 || cap_rdata !== ref_word(32'h24)) begin n_fail++; $display("FAIL rmid_after: got lat %0d rdata %h want 3 %h", cap_lat, cap_rdata, ref_word(32'h24)); end
    endtask

    task automatic test_random();
        logic wr, e_err, e_split;
        logic [2:0] f3;
        logic [31:0] addr, wd, e_rdata;
        int e_lat, e_beats, w0;
        for (int it = 0; it < 80; it++) begin
            wr = 1'($urandom); f3 = 3'($urandom); wd = $urandom;
            addr = ($urandom % 8 == 0) ? $urandom : ($urandom % NB);
            e_err   = model_err(wr, f3, addr);
            e_split = !e_err && is_split(addr, f3);
            e_lat   = e_err ? 1 : (wr ? 2 : 3) + (e_split ? 1 : 0);
            e_beats = e_err ? 0 : (e_split ? 2 : 1);
            e_rdata = (e_err || wr) ? 32'h0 : model_load(addr, f3);
            w0 = int'(addr[9:2]);
            do_req(wr, f3, addr, wd);
            n_cmp++; if (cap_err !== e_err || cap_lat !== e_lat) begin n_fail++; $display("FAIL rnd_err_lat[%0d]: got err %b lat %0d want %b %0d (wr %b f3 %b addr %h)", it, cap_err, cap_lat, e_err, e_lat, wr, f3, addr); end
            n_cmp++; if (cap_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h (wr %b f3 %b addr %h)", it, cap_rdata, e_rdata, wr, f3, addr); end
            n_cmp++; if (cap_beats !== e_beats) begin n_fail++; $display("FAIL rnd_beats[%0d]: got %0d want %0d", it, cap_beats, e_beats); end
            if (e_beats > 0) begin
                n_cmp++; if (cap_a[0] !== AW'(w0) || cap_w[0] !== wr || cap_m[0] !== (wr ? exp_mask(addr, f3, w0) : 4'b0)) begin n_fail++; $display("FAIL rnd_beat0[%0d]: got addr %h wr %b mask %b want %h %b %b", it, cap_a[0], cap_w[0], cap_m[0], AW'(w0), wr, wr ? exp_mask(addr, f3, w0) : 4'b0); end
            end
            if (e_beats > 1) begin
                n_cmp++; if (cap_a[1] !== AW'((w0 + 1) % NW) || cap_m[1] !== (wr ? exp_mask(addr, f3, (w0 + 1) % NW) : 4'b0)) begin n_fail++; $display("FAIL rnd_beat1[%0d]: got addr %h mask %b want %h", it, cap_a[1], cap_m[1], AW'((w0 + 1) % NW)); end
            end
            if (wr && !e_err) model_store(addr, f3, wd);
        end
        @(negedge clk);
        for (int w = 0; w < NW; w++) begin
            n_cmp++; if (mem[w] !== ref_word(w)) begin n_fail++; $display("FAIL rnd_mem[%0d]: got %h want %h", w, mem[w], ref_word(w)); end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_req_funct3 = 3'b0;
        i_req_addr = 32'h0; i_req_wdata = 32'h0; pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
        test_reset();
        for (int w = 0; w < NW; w++) preload(w, $urandom);
        test_load_lb();
        test_store_sh();
        test_misalign();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tcm_lsu.md
# tcm_lsu

Load/store initiator for the data port of the core's tightly coupled memory. It accepts one RV32 load or store from the execute stage and drives the TCM port: chip-select, word address, write strobe, byte mask and write data. It captures read data from the TCM's registered output one cycle later, then aligns and sign- or zero-extends it and returns a single-cycle response. It sits between the pipeline's memory stage and the TCM data port.

## Interface
- MEM_ADDR_WIDTH, 8, TCM word-address width; TCM holds 2**MEM_ADDR_WIDTH 32-bit words.
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when high with i_req_valid.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RV32 funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-justified.
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  access rejected; qualified by o_rsp_valid.
- o_data_sel  out  1  TCM select.
- o_data_addr  out  MEM_ADDR_WIDTH  TCM word address (byte address bits [MEM_ADDR_WIDTH+1:2]).
- o_data_write  out  1  TCM write strobe.
- o_data_mask  out  4  TCM byte-lane enables.
- o_data  out  32  TCM write data.
- i_data  in  32  TCM read data; valid the cycle after the address is presented with o_data_sel.

## Operation
- States: IDLE, BEAT0, BEAT1, CAPTURE, RESP.
- o_req_ready = (state==IDLE) & ~i_reset. The accepted request is latched.
- Lane math: b = addr[1:0]; size mask = 1/3/F for byte/half/word.
  - 8-bit lane mask = sizemask << b. Beat0 uses bits [3:0]; beat1 uses bits [7:4].
  - 64-bit write data = wdata << 8b. Beat0 uses the low word; beat1 uses the high word.
  - A split is needed when the beat1 mask is nonzero.
- Beat1 word address = beat0 address + 1, modulo 2**MEM_ADDR_WIDTH (wraps to 0).
- Load result: take {beat1 data, beat0 data} >> 8b, then extend:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes through.
- Error, with no TCM access, for any of:
  - i_req_addr[31:MEM_ADDR_WIDTH+2] != 0;
  - an illegal funct3 (load 011, 110, 111; store 011 to 111);
  - a split needed while misalign support is compiled out.
- Transitions:
  - IDLE→BEAT0 on accept; IDLE→RESP on accept of an erroring request.
  - BEAT0→BEAT1 if split; else BEAT0→RESP for a store, BEAT0→CAPTURE for a load.
  - BEAT1→RESP for a store, BEAT1→CAPTURE for a load.
  - CAPTURE→RESP; RESP→IDLE.
- In BEAT0 and BEAT1: o_data_sel=1, and o_data_write=1 for stores, with that beat's address, mask and data.
  - For a split load, beat0 data is captured from i_data during BEAT1.
  - The final beat's data is captured during CAPTURE.
- Outside BEAT states: o_data_sel=0, o_data_write=0, o_data_mask=0. Address and data hold their last values.
- Reset values: all outputs 0 (o_req_ready is 0 while i_reset is high); state IDLE.
- Reset mid-operation: return to IDLE immediately. No response is issued. Strobes drop asynchronously, so no write happens at the next edge.

## Timing
- Latency is counted in cycles from the accept edge to the cycle o_rsp_valid is high:
  - error: 1
  - aligned store: 2
  - split store: 3
  - aligned load: 3
  - split load: 4
- One request in flight at a time. Back-to-back throughput equals latency + 1, since RESP→IDLE precedes the next accept.
- TCM outputs are registered (driven from latched request and state). No combinational path from i_req_* to o_data_*.

## Configuration
- LSU_MISALIGN_EN defined: misaligned LH, LHU, SH, LW and SW that cross a word boundary are split into two TCM beats as above.
- LSU_MISALIGN_EN undefined:
  - Misaligned half/word requests error: o_rsp_err=1, o_rsp_rdata=0, no TCM access, latency 1.
  - BEAT1 is unreachable.
  - Misaligned accesses inside one word (LH at offset 1) are still performed.

## Test plan
- Reset, then TCM word 0x10 = 0x8899AABB; LB at byte address 0x41 → one beat, o_data_addr=0x10, o_data_mask=0000; o_rsp_rdata=0xFFFFFFAA, err=0, latency 3.
- SH 0x1234 at byte address 0x42 → single write cycle, o_data_mask=1100, o_data[31:16]=0x1234; response latency 2.
- With LSU_MISALIGN_EN: words 0x10=0x44332211 and 0x11=0x88776655; LW at 0x43 → two beats (addresses 0x10, 0x11); o_rsp_rdata=0x77665544, latency 4.
- With LSU_MISALIGN_EN: SW 0xDDCCBBAA at 0x3FF (MEM_ADDR_WIDTH=8), issued on two cycles:
  - beat0: word 0xFF, mask 1000, data 0xAA000000;
  - beat1: word 0x00 (wrap), mask 0111, data 0x00DDCCBB.
- Errors: LW at 0x400, or funct3 011 → o_rsp_err=1, rdata 0, o_data_sel never high, latency 1. Without the macro, LW at 0x41 gives the same result.
- Assert i_reset during BEAT0 of a store → o_data_write drops immediately, TCM contents unchanged, no o_rsp_valid; a new request is accepted after reset release.
